// File: rtl/uart_pkg.sv
// uart_pkg
// Shared types and constants for the UART transmit path.
//   arb_state_t    : arbiter sequencing states (IDLE / LOAD / WAIT)
//   UART_DATA_W    : default byte width of the UART datapath
//   UART_MAX_BURST : default number of bytes a requester may send per grant
package uart_pkg;

    localparam int UART_DATA_W    = 8;
    localparam int UART_MAX_BURST = 16;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LOAD = 2'd1,
        WAIT = 2'd2
    } arb_state_t;

endpackage

// File: rtl/uart_tx_arbiter_rr_pick.sv
// rr_pick
// Combinational round-robin picker. Searches req upward starting at index
// ptr, wrapping modulo N_REQ, and returns the first set bit as a one-hot grant.
// Ports:
//   req   in  N_REQ  request vector
//   ptr   in  PTR_W  index where the search starts
//   grant out N_REQ  one-hot winner, 0 when no request
//   any   out 1      at least one request present
module rr_pick #(
    parameter int N_REQ = 4,
    localparam int PTR_W = (N_REQ > 1) ? $clog2(N_REQ) : 1
) (
    input  logic [N_REQ-1:0] req,
    input  logic [PTR_W-1:0] ptr,
    output logic [N_REQ-1:0] grant,
    output logic             any
);

    // One spare bit so ptr + k can exceed N_REQ-1 before the wrap correction.
    logic [PTR_W:0] pos;
    logic           found;

    always_comb begin
        grant = '0;
        found = 1'b0;
        pos   = '0;
        for (int k = 0; k < N_REQ; k++) begin
            pos = {1'b0, ptr} + (PTR_W+1)'(k);
            if (pos >= (PTR_W+1)'(N_REQ)) begin
                pos = pos - (PTR_W+1)'(N_REQ);
            end
            if (!found && req[pos[PTR_W-1:0]]) begin
                grant[pos[PTR_W-1:0]] = 1'b1;
                found                 = 1'b1;
            end
        end
    end

    assign any = |req;

endmodule

// File: rtl/uart_tx_arbiter.sv
// uart_tx_arbiter
// Shares one UART transmitter among N_REQ byte-stream requesters. A requester
// keeps the grant until it flags its last byte, sends MAX_BURST bytes, or drops
// req_valid between bytes. The next search starts just above the previous owner.
// Ports:
//   clk, reset  clock and synchronous active-high reset
//   req_valid   in  N_REQ         byte pending per requester
//   req_data    in  N_REQ*DATA_W  byte of requester i at [i*DATA_W +: DATA_W]
//   req_last    in  N_REQ         byte is the last of its message
//   req_ready   out N_REQ         one-hot, byte of the owner accepted this cycle
//   tx_start    out 1             pulse, UART loads tx_data
//   tx_data     out DATA_W        registered byte, held until next tx_start
//   tx_busy     in  1             UART shifting a frame
//   tx_done     in  1             pulse at end of stop bit
//   gnt         out N_REQ         one-hot current owner, 0 when idle
//   arb_busy    out 1             grant held
module uart_tx_arbiter
    import uart_pkg::*;
#(
    parameter int N_REQ     = 4,
    parameter int DATA_W    = UART_DATA_W,
    parameter int MAX_BURST = UART_MAX_BURST
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic [N_REQ-1:0]        req_valid,
    input  logic [N_REQ*DATA_W-1:0] req_data,
    input  logic [N_REQ-1:0]        req_last,
    output logic [N_REQ-1:0]        req_ready,
    output logic                    tx_start,
    output logic [DATA_W-1:0]       tx_data,
    input  logic                    tx_busy,
    input  logic                    tx_done,
    output logic [N_REQ-1:0]        gnt,
    output logic                    arb_busy
);

    localparam int PTR_W = $clog2(N_REQ);
    localparam int CNT_W = $clog2(MAX_BURST + 1);

    arb_state_t         state_reg;
    logic [N_REQ-1:0]   gnt_reg;
    logic [PTR_W-1:0]   gnt_idx_reg;
    logic [PTR_W-1:0]   rr_ptr_reg;
    logic [CNT_W-1:0]   burst_cnt_reg;
    logic               last_seen_reg;
    logic               tx_start_reg;
    logic [DATA_W-1:0]  tx_data_reg;

    logic [N_REQ-1:0]   pick_gnt;
    logic               pick_any;
    logic [PTR_W-1:0]   pick_idx;
    logic [PTR_W-1:0]   ptr_next;

    logic [DATA_W-1:0]  req_bytes [N_REQ];
    logic [DATA_W-1:0]  owner_byte;
    logic               owner_valid;
    logic               owner_last;
    logic               load_accept;

    rr_pick #(
        .N_REQ (N_REQ)
    ) u_rr_pick (
        .req   (req_valid),
        .ptr   (rr_ptr_reg),
        .grant (pick_gnt),
        .any   (pick_any)
    );

    // Per-requester byte lanes and the one-hot ready strobe.
    generate
        for (genvar gi = 0; gi < N_REQ; gi++) begin : g_lane
            assign req_bytes[gi] = req_data[gi*DATA_W +: DATA_W];
            assign req_ready[gi] = load_accept & gnt_reg[gi];
        end
    endgenerate

    always_comb begin
        pick_idx = '0;
        for (int k = 0; k < N_REQ; k++) begin
            if (pick_gnt[k]) begin
                pick_idx = PTR_W'(k);
            end
        end
    end

    assign owner_valid = |(req_valid & gnt_reg);
    assign owner_last  = |(req_last & gnt_reg);
    assign owner_byte  = req_bytes[gnt_idx_reg];

    // Accept only when the UART is free so tx_start never collides with tx_busy.
    assign load_accept = (state_reg == LOAD) && owner_valid && !tx_busy;

    assign ptr_next = (gnt_idx_reg == PTR_W'(N_REQ - 1)) ? '0
                                                        : gnt_idx_reg + PTR_W'(1);

    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg     <= IDLE;
            gnt_reg       <= '0;
            gnt_idx_reg   <= '0;
            rr_ptr_reg    <= '0;
            burst_cnt_reg <= '0;
            last_seen_reg <= 1'b0;
            tx_start_reg  <= 1'b0;
            tx_data_reg   <= '0;
        end else begin
            tx_start_reg <= 1'b0;
            case (state_reg)
                IDLE: begin
                    if (pick_any) begin
                        gnt_reg       <= pick_gnt;
                        gnt_idx_reg   <= pick_idx;
                        burst_cnt_reg <= '0;
                        last_seen_reg <= 1'b0;
                        state_reg     <= LOAD;
                    end
                end
                LOAD: begin
                    if (!owner_valid) begin
                        // Owner withdrew between bytes: give the UART away.
                        rr_ptr_reg <= ptr_next;
                        gnt_reg    <= '0;
                        state_reg  <= IDLE;
                    end else if (!tx_busy) begin
                        tx_data_reg   <= owner_byte;
                        tx_start_reg  <= 1'b1;
                        last_seen_reg <= owner_last;
                        burst_cnt_reg <= burst_cnt_reg + CNT_W'(1);
                        state_reg     <= WAIT;
                    end
                end
                WAIT: begin
                    if (tx_done) begin
                        if (last_seen_reg || (burst_cnt_reg == CNT_W'(MAX_BURST))) begin
                            rr_ptr_reg <= ptr_next;
                            gnt_reg    <= '0;
                            state_reg  <= IDLE;
                        end else begin
                            state_reg <= LOAD;
                        end
                    end
                end
                default: begin
                    gnt_reg   <= '0;
                    state_reg <= IDLE;
                end
            endcase
        end
    end

    assign tx_start = tx_start_reg;
    assign tx_data  = tx_data_reg;
    assign gnt      = gnt_reg;
    assign arb_busy = (state_reg != IDLE);

endmodule

// File: tb/tb_uart_tx_arbiter.sv
module tb_uart_tx_arbiter;

    localparam int N     = 4;
    localparam int DW    = 8;
    localparam int FRAME = 3;

    logic          clk;
    logic          reset;
    logic [N-1:0]  req_valid;
    logic [N*DW-1:0] req_data;
    logic [N-1:0]  req_last;
    logic [N-1:0]  req_ready;
    logic          tx_start;
    logic [DW-1:0] tx_data;
    logic          tx_busy;
    logic          tx_done;
    logic [N-1:0]  gnt;
    logic          arb_busy;

    uart_tx_arbiter #(
        .N_REQ     (N),
        .DATA_W    (DW),
        .MAX_BURST (4)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .req_valid (req_valid),
        .req_data  (req_data),
        .req_last  (req_last),
        .req_ready (req_ready),
        .tx_start  (tx_start),
        .tx_data   (tx_data),
        .tx_busy   (tx_busy),
        .tx_done   (tx_done),
        .gnt       (gnt),
        .arb_busy  (arb_busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // Direct drive vs. behavioural requesters / UART
    logic          req_auto = 1'b0;
    logic          uart_auto = 1'b0;
    logic [N-1:0]  tb_valid = '0;
    logic [N*DW-1:0] tb_data = '0;
    logic [N-1:0]  tb_last = '0;
    logic          tb_busy = 1'b0;
    logic          tb_done = 1'b0;

    logic [N-1:0]  auto_valid = '0;
    logic [N*DW-1:0] auto_data = '0;
    logic [N-1:0]  auto_last = '0;

    assign req_valid = req_auto ? auto_valid : tb_valid;
    assign req_data  = req_auto ? auto_data  : tb_data;
    assign req_last  = req_auto ? auto_last  : tb_last;

    // UART model: busy FRAME cycles after tx_start, then a one-cycle done.
    int   m_cnt = 0;
    logic m_done = 1'b0;
    always @(posedge clk) begin
        if (reset) begin
            m_cnt  <= 0;
            m_done <= 1'b0;
        end else begin
            m_done <= (m_cnt == 1);
            if (tx_start) m_cnt <= FRAME;
            else if (m_cnt != 0) m_cnt <= m_cnt - 1;
        end
    end
    assign tx_busy = uart_auto ? (m_cnt != 0) : tb_busy;
    assign tx_done = uart_auto ? m_done : tb_done;

    // Requester model: per-requester FIFO of {last, byte}
    logic [8:0] rmem [N][32];
    logic [4:0] rhead [N] = '{default: 5'd0};
    logic [4:0] rtail [N] = '{default: 5'd0};
    logic [N-1:0] ready_s = '0;

    always @(negedge clk) ready_s = req_ready;

    always @(posedge clk) begin
        #2;
        for (int i = 0; i < N; i++) begin
            if (req_auto && ready_s[i] && (rhead[i] != rtail[i]))
                rhead[i] = rhead[i] + 5'd1;
            auto_valid[i] = (rhead[i] != rtail[i]);
            auto_data[i*DW +: DW] = rmem[i][rhead[i]][7:0];
            auto_last[i] = auto_valid[i] & rmem[i][rhead[i]][8];
        end
    end

    task automatic enqueue(input int r, input logic [7:0] b, input logic l);
        rmem[r][rtail[r]] = {l, b};
        rtail[r] = rtail[r] + 5'd1;
    endtask

    function automatic int oh2i(input logic [N-1:0] v);
        for (int i = 0; i < N; i++) if (v[i]) return i;
        return 15;
    endfunction

    // Transaction log: owner*256 + byte at every tx_start
    int log_q[$];
    int gap_run = 0;
    int gap_max = 0;
    always @(negedge clk) begin
        if (!reset && tx_start) begin
            log_q.push_back(oh2i(gnt) * 256 + int'(tx_data));
            $display("tx_start owner=%0d data=%02h", oh2i(gnt), tx_data);
        end
        if (!reset && gnt == '0 && req_valid != '0) begin
            gap_run++;
            if (gap_run > gap_max) gap_max = gap_run;
        end else begin
            gap_run = 0;
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic do_reset();
        reset = 1'b1;
        tick();
        tick();
        reset = 1'b0;
    endtask

    task automatic wait_log(input string name, input int n, input int budget);
        int k = 0;
        while (log_q.size() < n && k < budget) begin
            tick();
            k++;
        end
        chk({name, "_count"}, log_q.size(), n);
    endtask

    task automatic wait_idle(input string name, input int budget);
        int k = 0;
        while (arb_busy && k < budget) begin
            tick();
            k++;
        end
        chk({name, "_idle"}, {31'd0, arb_busy}, 32'd0);
    endtask

    task automatic cmp_log(input string name, input int exp_q[$]);
        for (int j = 0; j < exp_q.size(); j++) begin
            chk($sformatf("%s[%0d]", name, j),
                (j < log_q.size()) ? log_q[j] : -1, exp_q[j]);
        end
    endtask

    typedef struct {
        logic [3:0]  valid;
        logic [3:0]  last;
        logic [31:0] data;
        logic        busy;
        logic        done;
        logic [3:0]  e_ready;
        logic [3:0]  e_gnt;
        logic        e_start;
        logic [7:0]  e_txd;
        logic        e_abusy;
    } vec_t;

    function automatic vec_t mk(input logic [3:0] v, input logic [3:0] l, input logic [31:0] d,
                                input logic b, input logic dn, input logic [3:0] er,
                                input logic [3:0] eg, input logic es, input logic [7:0] et,
                                input logic ea);
        vec_t t;
        t.valid = v; t.last = l; t.data = d; t.busy = b; t.done = dn;
        t.e_ready = er; t.e_gnt = eg; t.e_start = es; t.e_txd = et; t.e_abusy = ea;
        return t;
    endfunction

    vec_t vt [13];
    int   exp_q[$];
    int   bad;

    initial begin
        // Single requester 1: 0x41 then 0x42 (last), then a pointer probe.
        vt[0]  = mk(4'b0010, 4'b0000, 32'h0000_4100, 0, 0, 4'b0000, 4'b0000, 0, 8'h00, 0);
        vt[1]  = mk(4'b0010, 4'b0000, 32'h0000_4100, 0, 0, 4'b0010, 4'b0010, 0, 8'h00, 1);
        vt[2]  = mk(4'b0010, 4'b0010, 32'h0000_4200, 0, 0, 4'b0000, 4'b0010, 1, 8'h41, 1);
        vt[3]  = mk(4'b0010, 4'b0010, 32'h0000_4200, 1, 0, 4'b0000, 4'b0010, 0, 8'h41, 1);
        vt[4]  = mk(4'b0010, 4'b0010, 32'h0000_4200, 0, 1, 4'b0000, 4'b0010, 0, 8'h41, 1);
        vt[5]  = mk(4'b0010, 4'b0010, 32'h0000_4200, 0, 0, 4'b0010, 4'b0010, 0, 8'h41, 1);
        vt[6]  = mk(4'b0000, 4'b0000, 32'h0000_0000, 0, 0, 4'b0000, 4'b0010, 1, 8'h42, 1);
        vt[7]  = mk(4'b0000, 4'b0000, 32'h0000_0000, 1, 0, 4'b0000, 4'b0010, 0, 8'h42, 1);
        vt[8]  = mk(4'b0000, 4'b0000, 32'h0000_0000, 0, 1, 4'b0000, 4'b0010, 0, 8'h42, 1);
        vt[9]  = mk(4'b0000, 4'b0000, 32'h0000_0000, 0, 0, 4'b0000, 4'b0000, 0, 8'h42, 0);
        // rr_ptr must now be 2: requests 0,1,2 -> requester 2 wins; it then withdraws.
        vt[10] = mk(4'b0111, 4'b0111, 32'h0000_0000, 0, 0, 4'b0000, 4'b0000, 0, 8'h42, 0);
        vt[11] = mk(4'b0000, 4'b0000, 32'h0000_0000, 0, 0, 4'b0000, 4'b0100, 0, 8'h42, 1);
        vt[12] = mk(4'b0000, 4'b0000, 32'h0000_0000, 0, 0, 4'b0000, 4'b0000, 0, 8'h42, 0);

        reset = 1'b1;
        tick();
        @(negedge clk);
        chk("rst_ready", {28'd0, req_ready}, 32'd0);
        chk("rst_start", {31'd0, tx_start}, 32'd0);
        chk("rst_txd",   {24'd0, tx_data}, 32'd0);
        chk("rst_gnt",   {28'd0, gnt}, 32'd0);
        chk("rst_abusy", {31'd0, arb_busy}, 32'd0);
        tick();
        reset = 1'b0;

        // ---- table-driven single-requester sequence
        for (int i = 0; i < 13; i++) begin
            tb_valid = vt[i].valid;
            tb_last  = vt[i].last;
            tb_data  = vt[i].data;
            tb_busy  = vt[i].busy;
            tb_done  = vt[i].done;
            @(negedge clk);
            $display("vec %0d ready=%b gnt=%b start=%b txd=%02h abusy=%b",
                     i, req_ready, gnt, tx_start, tx_data, arb_busy);
            chk($sformatf("v%0d_ready", i), {28'd0, req_ready}, {28'd0, vt[i].e_ready});
            chk($sformatf("v%0d_gnt", i),   {28'd0, gnt},       {28'd0, vt[i].e_gnt});
            chk($sformatf("v%0d_start", i), {31'd0, tx_start},  {31'd0, vt[i].e_start});
            chk($sformatf("v%0d_txd", i),   {24'd0, tx_data},   {24'd0, vt[i].e_txd});
            chk($sformatf("v%0d_abusy", i), {31'd0, arb_busy},  {31'd0, vt[i].e_abusy});
            tick();
        end
        tb_valid = '0; tb_last = '0; tb_data = '0; tb_busy = 0; tb_done = 0;

        // ---- all four requesters, rr_ptr=0
        do_reset();
        req_auto = 1'b1;
        uart_auto = 1'b1;
        log_q.delete();
        gap_max = 0;
        for (int i = 0; i < N; i++) enqueue(i, 8'hA0 + 8'(i), 1'b1);
        enqueue(0, 8'hB0, 1'b1);
        wait_log("rr", 5, 300);
        wait_idle("rr", 100);
        exp_q = '{'h0A0, 'h1A1, 'h2A2, 'h3A3, 'h0B0};
        cmp_log("rr", exp_q);
        chk("rr_gap", gap_max, 1);

        // ---- burst limit: req 2 streams 10 bytes, req 3 one byte
        log_q.delete();
        for (int j = 0; j < 10; j++) enqueue(2, 8'h10 + 8'(j), 1'b0);
        enqueue(3, 8'h30, 1'b1);
        wait_log("burst", 11, 600);
        wait_idle("burst", 100);
        exp_q.delete();
        for (int j = 0; j < 4; j++) exp_q.push_back('h210 + j);
        exp_q.push_back('h330);
        for (int j = 4; j < 10; j++) exp_q.push_back('h210 + j);
        cmp_log("burst", exp_q);

        // ---- tx_busy held high for 50 cycles after grant
        uart_auto = 1'b0;
        tb_busy = 1'b1;
        log_q.delete();
        enqueue(1, 8'h55, 1'b1);
        tick();
        bad = 0;
        for (int k = 0; k < 50; k++) begin
            @(negedge clk);
            if (req_ready != '0 || tx_start || gnt != 4'b0010) bad++;
            tick();
        end
        chk("hold_quiet", bad, 0);
        tb_busy = 1'b0;
        @(negedge clk);
        chk("hold_ready", {28'd0, req_ready}, 32'b0010);
        chk("hold_nostart", {31'd0, tx_start}, 32'd0);
        tick();
        @(negedge clk);
        chk("hold_start", {31'd0, tx_start}, 32'd1);
        chk("hold_txd", {24'd0, tx_data}, 32'h55);
        tick();
        tb_busy = 1'b1;
        tick();
        tb_busy = 1'b0;
        tb_done = 1'b1;
        tick();
        tb_done = 1'b0;
        @(negedge clk);
        chk("hold_release", {28'd0, gnt}, 32'd0);
        uart_auto = 1'b1;
        tick();

        // ---- requester 0 withdraws after 2 bytes
        log_q.delete();
        enqueue(0, 8'h61, 1'b0);
        enqueue(0, 8'h62, 1'b0);
        wait_log("wd", 2, 200);
        wait_idle("wd", 100);
        for (int k = 0; k < 10; k++) tick();
        chk("wd_no_extra", log_q.size(), 2);
        // rr_ptr is 1 now: with 0 and 1 requesting, 1 goes first
        enqueue(0, 8'h63, 1'b1);
        enqueue(1, 8'h64, 1'b1);
        wait_log("wd2", 4, 200);
        wait_idle("wd2", 100);
        exp_q = '{'h061, 'h062, 'h164, 'h063};
        cmp_log("wd", exp_q);

        // ---- reset in WAIT mid-frame
        log_q.delete();
        enqueue(2, 8'h77, 1'b1);
        wait_log("rstw", 1, 100);
        tick();
        @(negedge clk);
        chk("rstw_pre_gnt", {28'd0, gnt}, 32'b0100);
        tick();
        reset = 1'b1;
        tick();
        reset = 1'b0;
        @(negedge clk);
        chk("rstw_gnt", {28'd0, gnt}, 32'd0);
        chk("rstw_abusy", {31'd0, arb_busy}, 32'd0);
        chk("rstw_start", {31'd0, tx_start}, 32'd0);
        chk("rstw_txd", {24'd0, tx_data}, 32'd0);
        tick();
        log_q.delete();
        enqueue(1, 8'h81, 1'b1);
        enqueue(0, 8'h80, 1'b1);
        wait_log("rstw2", 2, 200);
        wait_idle("rstw2", 100);
        exp_q = '{'h080, 'h181};
        cmp_log("rstw", exp_q);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
